vai_rd_rsp_reorder: RTL and testbench

- AFU-side companion to the VTP/MPF wrapper, which runs with read-response sorting disabled.
- Accepts single-line virtual-address read requests from one client and issues them on CCI-P channel 0, with a tag in mdata.
- Buffers out-of-order c0 read responses and returns the data to the client in strict request order.
- Sits between one mux port's afu_TxPort.c0 / afu_RxPort.c0 and a client engine.

---
 rtl/vai_rd_rsp_reorder.sv | 162 ++++++++++++++++
 tb/tb_vai_rd_rsp_reorder.sv | 305 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vai_rd_rsp_reorder.sv
// VA read-request issuer with a tag-indexed reorder buffer that returns
// CCI-P c0 read-line responses to the client in strict request order.
module vai_rd_rsp_reorder #(
   parameter int TAG_BITS   = 6,
   parameter int ADDR_WIDTH = 42
) (
   input  logic                  pClk,
   input  logic                  pck_cp2af_softReset,

   input  logic                  cl_rd_valid,
   input  logic [ADDR_WIDTH-1:0] cl_rd_addr,
   output logic                  cl_rd_ready,

   output logic                  c0tx_valid,
   output logic [ADDR_WIDTH-1:0] c0tx_addr,
   output logic [15:0]           c0tx_mdata,
   input  logic                  c0_almfull,

   input  logic                  c0rx_rdrsp_valid,
   input  logic [15:0]           c0rx_mdata,
   input  logic [511:0]          c0rx_data,

   output logic                  cl_rsp_valid,
   output logic [511:0]          cl_rsp_data,
   input  logic                  cl_rsp_ready,

   output logic [TAG_BITS:0]     outstanding,
   output logic                  err_unexpected
);

   localparam int DEPTH = 1 << TAG_BITS;

   logic                  rst;

   logic [TAG_BITS-1:0]   r_tail;
   logic [TAG_BITS-1:0]   r_head;
   logic [TAG_BITS:0]     r_count;
   logic [DEPTH-1:0]      r_inflight;
   logic [DEPTH-1:0]      r_filled;

   logic                  r_c0tx_valid;
   logic [ADDR_WIDTH-1:0] r_c0tx_addr;
   logic [TAG_BITS-1:0]   r_c0tx_tag;

   logic                  r_out_valid;
   logic [511:0]          r_out_data;
   logic                  r_err;

   logic [511:0]          r_mem [DEPTH];
   logic [511:0]          r_rd_data;

   logic                  w_accept;
   logic                  w_pop;
   logic                  w_move;
   logic [TAG_BITS-1:0]   w_rsp_tag;
   logic                  w_tag_hi_bad;
   logic                  w_capture;
   logic                  w_bad_rsp;
   logic [TAG_BITS-1:0]   w_head_nxt;
   logic [TAG_BITS-1:0]   w_rd_addr;

   assign rst = pck_cp2af_softReset;

   // Count MSB set means all 2^TAG_BITS tags are allocated
   assign cl_rd_ready = !rst && !r_count[TAG_BITS] && !c0_almfull;
   assign w_accept    = cl_rd_valid && cl_rd_ready;

   assign w_pop  = r_out_valid && cl_rsp_ready;
   assign w_move = r_filled[r_head] && (!r_out_valid || cl_rsp_ready);

   assign w_rsp_tag    = c0rx_mdata[TAG_BITS-1:0];
   assign w_tag_hi_bad = (c0rx_mdata[15:TAG_BITS] != '0);
   assign w_capture    = c0rx_rdrsp_valid && !w_tag_hi_bad &&
                         r_inflight[w_rsp_tag] && !r_filled[w_rsp_tag];
   assign w_bad_rsp    = c0rx_rdrsp_valid && !w_capture;

   assign w_head_nxt = r_head + TAG_BITS'(1);
   // Prefetch the entry that will be head after this edge
   assign w_rd_addr  = w_move ? w_head_nxt : r_head;

   always_ff @(posedge pClk or posedge rst) begin
      if (rst) begin
         r_tail  <= '0;
         r_head  <= '0;
         r_count <= '0;
      end else begin
         if (w_accept) r_tail <= r_tail + TAG_BITS'(1);
         if (w_move)   r_head <= w_head_nxt;
         unique case ({w_accept, w_pop})
            2'b10:   r_count <= r_count + (TAG_BITS+1)'(1);
            2'b01:   r_count <= r_count - (TAG_BITS+1)'(1);
            default: r_count <= r_count;
         endcase
      end
   end

   always_ff @(posedge pClk or posedge rst) begin
      if (rst) begin
         r_inflight <= '0;
         r_filled   <= '0;
      end else begin
         if (w_accept) begin
            r_inflight[r_tail] <= 1'b1;
            r_filled[r_tail]   <= 1'b0;
         end
         if (w_capture) r_filled[w_rsp_tag] <= 1'b1;
         if (w_move) begin
            r_inflight[r_head] <= 1'b0;
            r_filled[r_head]   <= 1'b0;
         end
      end
   end

   always_ff @(posedge pClk or posedge rst) begin
      if (rst) begin
         r_c0tx_valid <= 1'b0;
         r_c0tx_addr  <= '0;
         r_c0tx_tag   <= '0;
      end else begin
         r_c0tx_valid <= w_accept;
         if (w_accept) begin
            r_c0tx_addr <= cl_rd_addr;
            r_c0tx_tag  <= r_tail;
         end
      end
   end

   // Write-first read so a line landing on the prefetch address is seen
   always_ff @(posedge pClk) begin
      if (w_capture) r_mem[w_rsp_tag] <= c0rx_data;
      if (w_capture && (w_rsp_tag == w_rd_addr))
         r_rd_data <= c0rx_data;
      else
         r_rd_data <= r_mem[w_rd_addr];
   end

   always_ff @(posedge pClk or posedge rst) begin
      if (rst) begin
         r_out_valid <= 1'b0;
         r_out_data  <= '0;
      end else if (w_move) begin
         r_out_valid <= 1'b1;
         r_out_data  <= r_rd_data;
      end else if (w_pop) begin
         r_out_valid <= 1'b0;
      end
   end

   always_ff @(posedge pClk or posedge rst) begin
      if (rst)            r_err <= 1'b0;
      else if (w_bad_rsp) r_err <= 1'b1;
   end

   assign c0tx_valid     = r_c0tx_valid;
   assign c0tx_addr      = r_c0tx_addr;
   assign c0tx_mdata     = {{(16-TAG_BITS){1'b0}}, r_c0tx_tag};
   assign cl_rsp_valid   = r_out_valid;
   assign cl_rsp_data    = r_out_data;
   assign outstanding    = r_count;
   assign err_unexpected = r_err;

endmodule

// File: tb/tb_vai_rd_rsp_reorder.sv
// Directed bench for vai_rd_rsp_reorder: ordering, latency, full/wrap,
// back-pressure, stray responses and mid-run reset.
module tb_vai_rd_rsp_reorder;

   logic          pClk;
   logic          rst;
   logic          cl_rd_valid;
   logic [41:0]   cl_rd_addr;
   logic          cl_rd_ready;
   logic          c0tx_valid;
   logic [41:0]   c0tx_addr;
   logic [15:0]   c0tx_mdata;
   logic          c0_almfull;
   logic          c0rx_rdrsp_valid;
   logic [15:0]   c0rx_mdata;
   logic [511:0]  c0rx_data;
   logic          cl_rsp_valid;
   logic [511:0]  cl_rsp_data;
   logic          cl_rsp_ready;
   logic [6:0]    outstanding;
   logic          err_unexpected;

   int n_asrt = 0;
   int n_fail = 0;

   vai_rd_rsp_reorder #(.TAG_BITS(6), .ADDR_WIDTH(42)) dut (
      .pClk                (pClk),
      .pck_cp2af_softReset (rst),
      .cl_rd_valid         (cl_rd_valid),
      .cl_rd_addr          (cl_rd_addr),
      .cl_rd_ready         (cl_rd_ready),
      .c0tx_valid          (c0tx_valid),
      .c0tx_addr           (c0tx_addr),
      .c0tx_mdata          (c0tx_mdata),
      .c0_almfull          (c0_almfull),
      .c0rx_rdrsp_valid    (c0rx_rdrsp_valid),
      .c0rx_mdata          (c0rx_mdata),
      .c0rx_data           (c0rx_data),
      .cl_rsp_valid        (cl_rsp_valid),
      .cl_rsp_data         (cl_rsp_data),
      .cl_rsp_ready        (cl_rsp_ready),
      .outstanding         (outstanding),
      .err_unexpected      (err_unexpected)
   );

   initial pClk = 1'b0;
   always #5 pClk = ~pClk;

   task automatic tick();
      @(posedge pClk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [511:0] obs,
                      input logic [511:0] exp);
      n_asrt++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic clr_in();
      cl_rd_valid      = 1'b0;
      cl_rd_addr       = '0;
      c0_almfull       = 1'b0;
      c0rx_rdrsp_valid = 1'b0;
      c0rx_mdata       = '0;
      c0rx_data        = '0;
   endtask

   task automatic rsp(input int t, input logic [511:0] d);
      c0rx_rdrsp_valid = 1'b1;
      c0rx_mdata       = 16'(t);
      c0rx_data        = d;
   endtask

   task automatic rst_pulse();
      tick();
      rst = 1'b1;
      clr_in();
      tick();
      rst = 1'b0;
   endtask

   initial begin
      rst = 1'b0;
      cl_rsp_ready = 1'b1;
      clr_in();

      // reset state
      #2 rst = 1'b1;
      #1;
      chk("rst_rd_ready", cl_rd_ready, 0);
      chk("rst_c0tx_valid", c0tx_valid, 0);
      chk("rst_rsp_valid", cl_rsp_valid, 0);
      chk("rst_outstanding", outstanding, 0);
      chk("rst_err", err_unexpected, 0);
      tick();
      tick();
      rst = 1'b0;

      // in-order
      for (int i = 0; i < 4; i++) begin
         cl_rd_valid = 1'b1;
         cl_rd_addr  = 42'h100 + 42'(i);
         #1 chk("io_rd_ready", cl_rd_ready, 1);
         tick();
         chk("io_c0tx_valid", c0tx_valid, 1);
         chk("io_c0tx_mdata", c0tx_mdata, i);
         chk("io_c0tx_addr", c0tx_addr, 'h100 + i);
      end
      cl_rd_valid = 1'b0;
      tick();
      chk("io_c0tx_pulse", c0tx_valid, 0);
      chk("io_outstanding4", outstanding, 4);
      rsp(0, 'h100);
      tick();
      chk("io_lat_n1", cl_rsp_valid, 0);
      rsp(1, 'h101);
      tick();
      chk("io_v0", cl_rsp_valid, 1);
      chk("io_d0", cl_rsp_data, 'h100);
      rsp(2, 'h102);
      tick();
      chk("io_d1", cl_rsp_data, 'h101);
      rsp(3, 'h103);
      tick();
      chk("io_d2", cl_rsp_data, 'h102);
      c0rx_rdrsp_valid = 1'b0;
      tick();
      chk("io_v3", cl_rsp_valid, 1);
      chk("io_d3", cl_rsp_data, 'h103);
      tick();
      chk("io_done_valid", cl_rsp_valid, 0);
      chk("io_outstanding0", outstanding, 0);

      // reverse order
      rst_pulse();
      cl_rd_valid = 1'b1;
      for (int i = 0; i < 8; i++) begin
         cl_rd_addr = 42'h200 + 42'(i);
         tick();
      end
      cl_rd_valid = 1'b0;
      for (int t = 7; t >= 1; t--) begin
         rsp(t, 'h200 + t);
         tick();
         chk("rv_hold", cl_rsp_valid, 0);
      end
      rsp(0, 'h200);
      tick();
      chk("rv_lat_n1", cl_rsp_valid, 0);
      c0rx_rdrsp_valid = 1'b0;
      tick();
      chk("rv_lat_n2", cl_rsp_valid, 1);
      chk("rv_d0", cl_rsp_data, 'h200);
      for (int k = 1; k < 8; k++) begin
         tick();
         chk("rv_stream_v", cl_rsp_valid, 1);
         chk("rv_stream_d", cl_rsp_data, 'h200 + k);
      end
      tick();
      chk("rv_end_valid", cl_rsp_valid, 0);
      chk("rv_outstanding0", outstanding, 0);

      // full and wrap
      rst_pulse();
      cl_rd_valid = 1'b1;
      for (int i = 0; i < 64; i++) begin
         cl_rd_addr = 42'(i);
         tick();
      end
      chk("fw_mdata63", c0tx_mdata, 63);
      chk("fw_outstanding64", outstanding, 64);
      chk("fw_rd_ready_full", cl_rd_ready, 0);
      tick();
      chk("fw_no_issue", c0tx_valid, 0);
      cl_rd_valid = 1'b0;
      rsp(0, 'haaa);
      tick();
      c0rx_rdrsp_valid = 1'b0;
      tick();
      chk("fw_rsp_valid", cl_rsp_valid, 1);
      chk("fw_rsp_data", cl_rsp_data, 'haaa);
      chk("fw_ready_before_pop", cl_rd_ready, 0);
      tick();
      chk("fw_outstanding63", outstanding, 63);
      chk("fw_ready_after_pop", cl_rd_ready, 1);
      cl_rd_valid = 1'b1;
      cl_rd_addr  = 42'h999;
      tick();
      chk("fw_wrap_valid", c0tx_valid, 1);
      chk("fw_wrap_mdata", c0tx_mdata, 0);
      chk("fw_wrap_addr", c0tx_addr, 'h999);
      chk("fw_refull", cl_rd_ready, 0);
      cl_rd_valid = 1'b0;

      // back-pressure
      rst_pulse();
      cl_rsp_ready = 1'b0;
      c0_almfull   = 1'b1;
      cl_rd_valid  = 1'b1;
      cl_rd_addr   = 42'h300;
      for (int i = 0; i < 10; i++) begin
         tick();
         chk("bp_rd_ready", cl_rd_ready, 0);
         chk("bp_c0tx_valid", c0tx_valid, 0);
      end
      c0_almfull = 1'b0;
      #1 chk("bp_release_ready", cl_rd_ready, 1);
      tick();
      chk("bp_issue_valid", c0tx_valid, 1);
      chk("bp_issue_mdata", c0tx_mdata, 0);
      chk("bp_issue_addr", c0tx_addr, 'h300);
      cl_rd_valid = 1'b0;
      rsp(0, 'hdead);
      tick();
      c0rx_rdrsp_valid = 1'b0;
      tick();
      chk("bp_rsp_valid", cl_rsp_valid, 1);
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("bp_hold_valid", cl_rsp_valid, 1);
         chk("bp_hold_data", cl_rsp_data, 'hdead);
      end
      cl_rsp_ready = 1'b1;
      tick();
      chk("bp_popped", cl_rsp_valid, 0);
      chk("bp_outstanding0", outstanding, 0);

      // unexpected responses
      rst_pulse();
      chk("ux_err_clear", err_unexpected, 0);
      rsp(5, 'h1);
      tick();
      c0rx_rdrsp_valid = 1'b0;
      chk("ux_err_stray", err_unexpected, 1);
      chk("ux_count", outstanding, 0);
      tick();
      tick();
      tick();
      chk("ux_err_sticky", err_unexpected, 1);
      chk("ux_no_beat", cl_rsp_valid, 0);
      rst_pulse();
      cl_rsp_ready = 1'b0;
      cl_rd_valid  = 1'b1;
      cl_rd_addr   = 42'h400;
      tick();
      cl_rd_valid = 1'b0;
      rsp(0, 'h55);
      tick();
      chk("ux_first_ok", err_unexpected, 0);
      rsp(0, 'h66);
      tick();
      c0rx_rdrsp_valid = 1'b0;
      chk("ux_dup_err", err_unexpected, 1);
      chk("ux_dup_data", cl_rsp_data, 'h55);
      chk("ux_dup_count", outstanding, 1);
      cl_rsp_ready = 1'b1;
      tick();
      chk("ux_final_count", outstanding, 0);

      // reset mid-operation
      rst_pulse();
      cl_rsp_ready = 1'b0;
      cl_rd_valid  = 1'b1;
      for (int i = 0; i < 10; i++) begin
         cl_rd_addr = 42'h500 + 42'(i);
         tick();
      end
      cl_rd_valid = 1'b0;
      for (int t = 1; t <= 3; t++) begin
         rsp(t, 'h500 + t);
         tick();
      end
      c0rx_rdrsp_valid = 1'b0;
      chk("rm_outstanding10", outstanding, 10);
      chk("rm_no_beat", cl_rsp_valid, 0);
      rst = 1'b1;
      #1;
      chk("rm_c0tx_valid", c0tx_valid, 0);
      chk("rm_c0tx_mdata", c0tx_mdata, 0);
      chk("rm_outstanding0", outstanding, 0);
      chk("rm_rd_ready", cl_rd_ready, 0);
      chk("rm_rsp_valid", cl_rsp_valid, 0);
      tick();
      rst = 1'b0;
      rsp(2, 'h502);
      tick();
      c0rx_rdrsp_valid = 1'b0;
      chk("rm_late_err", err_unexpected, 1);
      cl_rd_valid = 1'b1;
      cl_rd_addr  = 42'h600;
      tick();
      cl_rd_valid = 1'b0;
      chk("rm_fresh_valid", c0tx_valid, 1);
      chk("rm_fresh_mdata", c0tx_mdata, 0);

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_asrt, n_fail);
      $finish;
   end

endmodule
